// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default Williams raster timing and sync-lock state encoding
package video_timing_pkg;
  localparam int WMS_PIX_DIV  = 2;
  localparam int WMS_HB_START = 336;
  localparam int WMS_HB_END   = 40;
  localparam int WMS_VB_START = 246;
  localparam int WMS_VB_END   = 6;
  typedef enum logic [1:0] {LK_UNLOCK, LK_TRACK, LK_LOCK} lock_state_t;
endpackage

// File: rtl/video_blank_gen_sat_counter.sv
// sat_counter: enable-driven up counter with sync clear that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 11
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  assign sat = &cnt;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !sat) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/video_blank_gen.sv
// video_blank_gen: recovers pixel enable, blanking, beam position and sync lock from raw HSync/VSync
module video_blank_gen
  import video_timing_pkg::*;
#(
  parameter int PIX_DIV  = WMS_PIX_DIV,
  parameter int CNT_W    = 11,
  parameter int OFS_W    = 4,
  parameter int HB_START = WMS_HB_START,
  parameter int HB_END   = WMS_HB_END,
  parameter int VB_START = WMS_VB_START,
  parameter int VB_END   = WMS_VB_END
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [OFS_W-1:0] h_ofs,
  input  logic [OFS_W-1:0] v_ofs,
  output logic             ce_pix,
  output logic             hblank,
  output logic             vblank,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             sync_ok
);
  localparam int SUB_W = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(PIX_DIV - 1);
  if (HB_START == HB_END) begin : g_hb_bad
    $error("video_blank_gen: HB_START must differ from HB_END");
  end
  if (VB_START == VB_END) begin : g_vb_bad
    $error("video_blank_gen: VB_START must differ from VB_END");
  end
  if (PIX_DIV < 1 || (PIX_DIV & (PIX_DIV - 1)) != 0) begin : g_div_bad
    $error("video_blank_gen: PIX_DIV must be a power of two");
  end
  logic hs_q, vs_q, hs_rise, vs_rise, hsat, vsat;
  logic [SUB_W-1:0] sub, sub_nx;
  logic [OFS_W-1:0] h_ofs_l, v_ofs_l;
  logic [CNT_W-1:0] line_cnt, frame_cnt, hb_on, hb_off, vb_on, vb_off;
  lock_state_t state, state_nx;
  assign hs_rise = hs_in & ~hs_q;
  assign vs_rise = hs_rise & vs_in & ~vs_q;
  assign sub_nx  = (hs_rise || sub == SUB_MAX) ? '0 : sub + SUB_W'(1);
  // Totals count the pixel/line whose increment is displaced by the sync edge
  assign line_cnt  = hsat ? hcnt : hcnt + CNT_W'(ce_pix);
  assign frame_cnt = vsat ? vcnt : vcnt + CNT_W'(1);
  assign hb_on  = CNT_W'(HB_START) + CNT_W'($signed(h_ofs_l));
  assign hb_off = CNT_W'(HB_END)   + CNT_W'($signed(h_ofs_l));
  assign vb_on  = CNT_W'(VB_START) + CNT_W'($signed(v_ofs_l));
  assign vb_off = CNT_W'(VB_END)   + CNT_W'($signed(v_ofs_l));
  assign sync_ok = state == LK_LOCK;
  sat_counter #(.CNT_W(CNT_W)) u_hcnt (
    .clk_sys(clk_sys), .reset_n(reset_n), .en(ce_pix), .clr(hs_rise), .cnt(hcnt), .sat(hsat)
  );
  sat_counter #(.CNT_W(CNT_W)) u_vcnt (
    .clk_sys(clk_sys), .reset_n(reset_n), .en(hs_rise), .clr(vs_rise), .cnt(vcnt), .sat(vsat)
  );
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      sub         <= '0;
      ce_pix      <= 1'b0;
      h_ofs_l     <= '0;
      v_ofs_l     <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      state       <= LK_UNLOCK;
    end else begin
      hs_q   <= hs_in;
      sub    <= sub_nx;
      ce_pix <= sub_nx == SUB_MAX;
      state  <= state_nx;
      if (hs_rise) begin
        vs_q     <= vs_in;
        line_len <= line_cnt;
      end
      // Offsets only move at frame start so a frame is never drawn with two shifts
      if (vs_rise) begin
        frame_lines <= frame_cnt;
        h_ofs_l     <= h_ofs;
        v_ofs_l     <= v_ofs;
      end
      hblank <= hcnt == hb_on ? 1'b1 : hcnt == hb_off ? 1'b0 : hblank;
      vblank <= vcnt == vb_on ? 1'b1 : vcnt == vb_off ? 1'b0 : vblank;
    end
  always_comb begin
    state_nx = state;
    if (hsat || vsat) state_nx = LK_UNLOCK;
    else if (vs_rise) state_nx = state == LK_UNLOCK ? LK_TRACK :
                                 frame_cnt == frame_lines ? LK_LOCK : LK_TRACK;
  end
endmodule
